// File: rtl/ifetch_queue_if.sv
// Fetch-queue handshake bundle: memory request/response, redirect and decode-side signals.
// master = the fetch queue, slave = memory/redirect/decode environment.
interface ifetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order fetches, buffers responses for decode, flushes on redirect.
// Optional macro IFQ_PERF_CNT_EN adds saturating stall/flush performance counters.
module ifetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic              clk,
  input  logic              reset,
  ifetch_queue_if.master    bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   MAX_OUT    = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]     DEPTH_C    = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     q_inst  [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] pend_pc [DEPTH];
  logic [PW-1:0]   q_head, q_tail, pend_head, pend_tail;
  logic [CW-1:0]   q_count, outstanding, discard, out_next;
  logic            req_fire, push, pop;

  assign bus.id_valid       = !reset && (q_count != '0);
  assign bus.id_inst        = bus.id_valid ? q_inst[q_head] : 32'd0;
  assign bus.id_pc          = bus.id_valid ? q_pc[q_head] : '0;
  assign bus.imem_req_addr  = fetch_pc & ALIGN_MASK;
  // Every accepted request reserves a queue slot, so responses can never overflow.
  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (outstanding < MAX_OUT)
                              && (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_C);

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign push     = bus.imem_rsp_valid && (discard == '0) && !bus.redirect_valid;
  assign pop      = bus.id_valid && bus.id_ready && !bus.redirect_valid;

  always_comb begin
    out_next = outstanding;
    if (req_fire)           out_next = out_next + CW'(1);
    if (bus.imem_rsp_valid) out_next = out_next - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC & ALIGN_MASK;
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
      pend_head   <= '0;
      pend_tail   <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (bus.redirect_valid) begin
        // Everything still in flight becomes stale; a response landing now already counts.
        fetch_pc  <= bus.redirect_pc & ALIGN_MASK;
        q_head    <= '0;
        q_tail    <= '0;
        q_count   <= '0;
        pend_head <= '0;
        pend_tail <= '0;
        discard   <= outstanding - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc  <= fetch_pc + XLEN'(4);
          pend_tail <= pend_tail + PW'(1);
        end
        if (bus.imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          q_tail    <= q_tail + PW'(1);
          pend_head <= pend_head + PW'(1);
        end
        if (pop) q_head <= q_head + PW'(1);
        case ({push, pop})
          2'b10:   q_count <= q_count + CW'(1);
          2'b01:   q_count <= q_count - CW'(1);
          default: q_count <= q_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pend_pc[pend_tail] <= bus.imem_req_addr;
    if (push) begin
      q_inst[q_tail] <= bus.imem_rsp_data;
      q_pc[q_tail]   <= pend_pc[pend_head];
    end
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.id_valid && !bus.id_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.redirect_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed vector bench for ifetch_queue; memory answers accepted requests in order with data = addr + 0x10000000.
module tb_ifetch_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifetch_queue_if #(.XLEN(32)) bus ();

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  ifetch_queue #(
    .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        rdy_req;
    logic        rsp_en;
    logic        redir;
    logic [31:0] redir_pc;
    logic        id_rdy;
    logic        chk;
    logic        e_req_v;
    logic [31:0] e_addr;
    logic        e_id_v;
    logic [31:0] e_pc;
    logic        chk_perf;
    int          e_stall;
    int          e_flush;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];
  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rsp_en, logic redir, logic [31:0] rpc, logic id_rdy,
                              logic erv, logic [31:0] ea, logic eiv, logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.rdy_req = 1'b1; v.rsp_en = rsp_en; v.redir = redir; v.redir_pc = rpc;
    v.id_rdy = id_rdy; v.chk = 1'b1; v.e_req_v = erv; v.e_addr = ea; v.e_id_v = eiv; v.e_pc = epc;
    v.chk_perf = 1'b0; v.e_stall = 0; v.e_flush = 0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst;
    if (v.rst) mq.delete();
    bus.imem_req_ready = v.rdy_req;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.redir_pc;
    bus.id_ready       = v.id_rdy;
    if (v.rsp_en && mq.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mq.pop_front() + 32'h1000_0000;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    #1;
    if (v.chk) begin
      check({tag, " req_valid"}, 32'(bus.imem_req_valid), 32'(v.e_req_v));
      if (v.e_req_v) check({tag, " req_addr"}, bus.imem_req_addr, v.e_addr);
      check({tag, " id_valid"}, 32'(bus.id_valid), 32'(v.e_id_v));
      if (v.e_id_v || v.rst) begin
        check({tag, " id_pc"}, bus.id_pc, v.e_id_v ? v.e_pc : 32'h0);
        check({tag, " id_inst"}, bus.id_inst, v.e_id_v ? v.e_pc + 32'h1000_0000 : 32'h0);
      end
`ifdef IFQ_PERF_CNT_EN
      if (v.chk_perf) begin
        check({tag, " stall_cnt"}, perf_stall_cnt, 32'(v.e_stall));
        check({tag, " flush_cnt"}, perf_flush_cnt, 32'(v.e_flush));
      end
`endif
    end
    if (bus.imem_req_valid && bus.imem_req_ready) mq.push_back(bus.imem_req_addr);
  endtask

  initial begin
    vec_t w;
    bit   seen;
    int   n;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;

    //            rst rsp red rpc            idr  reqv addr           idv pc
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0));        // 0
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0));        // first fetch
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h4,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h8,        1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'hC,        1, 32'h4));        // 5
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h10,       1, 32'h8));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h14,       1, 32'hC));        // decode stall
    vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h18,       1, 32'hC));
    for (int i = 9; i <= 16; i++)
      vecs.push_back(mk(0, 1, 0, 32'h0,      0,   0, 32'h0,        1, 32'hC));        // full
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'h0,        1, 32'hC));        // 17 release
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h1C,       1, 32'h10));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h20,       1, 32'h14));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h24,       1, 32'h18));       // 20
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h28,       1, 32'h1C));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h2C,       1, 32'h20));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1,   1, 32'h30,       1, 32'h24));       // memory stalls
    vecs.push_back(mk(0, 0, 0, 32'h0,        1,   0, 32'h0,        1, 32'h28));       // 2 outstanding
    vecs.push_back(mk(0, 0, 1, 32'h103,      1,   0, 32'h0,        0, 32'h0));        // 25 redirect
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0));        // stale dropped
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h100,      0, 32'h0));        // stale dropped
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h104,      0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h108,      1, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h10C,      1, 32'h104));      // 30
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC,1,   0, 32'h0,        1, 32'h108));      // redirect vs pop
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'hFFFF_FFFC,0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0));        // wrap
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h4,        1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h8,        1, 32'h0));        // 35
    vecs.push_back(mk(0, 1, 1, 32'h200,      1,   0, 32'h0,        1, 32'h4));        // back-to-back
    vecs.push_back(mk(0, 1, 1, 32'h300,      1,   0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h300,      0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h304,      0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h308,      1, 32'h300));      // 40
    vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h30C,      1, 32'h304));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0,   1, 32'h310,      1, 32'h304));      // 3 queued, 1 out
    vecs.push_back(mk(1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0));        // reset mid-run
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h4,        0, 32'h0));        // 45
    vecs.push_back(mk(0, 1, 0, 32'h0,        1,   1, 32'h8,        1, 32'h0));

    vecs[32].chk_perf = 1'b1; vecs[32].e_stall = 10; vecs[32].e_flush = 2;
    vecs[43].chk_perf = 1'b1; vecs[43].e_stall = 12; vecs[43].e_flush = 4;
    vecs[45].chk_perf = 1'b1; vecs[45].e_stall = 0;  vecs[45].e_flush = 0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Second redirect while the first one's stale responses are still draining.
    run_vec(mk(0, 0, 0, 32'h0,   1, 1, 32'hC,   1, 32'h4), "h0");
    run_vec(mk(0, 0, 1, 32'h400, 1, 0, 32'h0,   0, 32'h0), "h1");
    run_vec(mk(0, 1, 1, 32'h500, 1, 0, 32'h0,   0, 32'h0), "h2");
    run_vec(mk(0, 1, 0, 32'h0,   1, 1, 32'h500, 0, 32'h0), "h3");
    w = mk(0, 1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
    w.chk = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      run_vec(w, "wait");
      n++;
      seen = bus.id_valid;
    end
    check("redir2 id_valid seen", 32'(seen), 32'h1);
    if (seen) begin
      check("redir2 first id_pc", bus.id_pc, 32'h500);
      check("redir2 first id_inst", bus.id_inst, 32'h1000_0500);
    end

    // Memory back-pressure: address holds until accepted.
    w = mk(0, 1, 0, 32'h0, 0, 1, 32'h50C, 1, 32'h504);
    w.rdy_req = 1'b0;
    run_vec(w, "h6");
    run_vec(w, "h7");
    run_vec(mk(0, 1, 0, 32'h0, 1, 1, 32'h50C, 1, 32'h504), "h8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
